// File: rtl/framed_tx_pkg.sv
// Shared types and default constants for the framed serial bit transmitter.
// The state encoding is fixed at 3 bits so it can be probed on external debug buses.
package framed_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } tx_state_e;

    localparam int DEF_PRE_W      = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_GAP_CYCLES = 2;
    localparam logic [DEF_PRE_W-1:0] DEF_PREAMBLE = 4'b1010;

    // Sizes the shared bit counter so that it can index the longest phase.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/framed_bit_transmitter_if.sv
// Payload handshake and serial output bundle of the framed bit transmitter.
// The producer side uses master; the transmitter uses slave.
interface framed_bit_transmitter_if
    import framed_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              dout;
    logic              dout_valid;
    logic              frame_start;
    logic              busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  dout,
        input  dout_valid,
        input  frame_start,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output dout,
        output dout_valid,
        output frame_start,
        output busy
    );

endinterface

// File: rtl/framed_bit_transmitter_piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first. next_msb is the bit that
// will sit in the MSB after this edge, so the caller can register it directly.
module piso_shift_reg
    import framed_tx_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             next_msb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = sr_q << 1;
        sr_d    = sr_q;
        if (load) begin
            sr_d = load_data;
        end else if (shift) begin
            sr_d = shifted;
        end
    end

    assign next_msb = sr_d[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/framed_bit_transmitter.sv
// Serial frame generator: preamble, payload MSB-first, even parity, then an idle gap.
// All serial outputs are registered; the FSM picks which bit is loaded into dout next.
module framed_bit_transmitter
    import framed_tx_pkg::*;
#(
    parameter int               DATA_W     = DEF_DATA_W,
    parameter int               PRE_W      = DEF_PRE_W,
    parameter logic [PRE_W-1:0] PREAMBLE   = DEF_PREAMBLE,
    parameter int               GAP_CYCLES = DEF_GAP_CYCLES
) (
    input logic                     clk,
    input logic                     reset,
    framed_bit_transmitter_if.slave bus
);

    localparam int CNT_W = $clog2(max3(PRE_W, DATA_W, GAP_CYCLES) + 1);

    tx_state_e        state_q;
    tx_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             parity_q;
    logic             parity_d;
    logic             dout_q;
    logic             dout_d;
    logic             dout_valid_q;
    logic             dout_valid_d;
    logic             frame_start_q;
    logic             frame_start_d;

    logic in_ready;
    logic accept;
    logic pre_shift;
    logic data_shift;
    logic pre_bit;
    logic data_bit;

    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = bus.in_valid && in_ready;

    piso_shift_reg #(
        .WIDTH(PRE_W)
    ) u_pre_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .shift    (pre_shift),
        .load_data(PREAMBLE),
        .next_msb (pre_bit)
    );

    piso_shift_reg #(
        .WIDTH(DATA_W)
    ) u_data_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .shift    (data_shift),
        .load_data(bus.in_data),
        .next_msb (data_bit)
    );

    // cnt_q counts bits already shown in the current phase; the last bit of a
    // phase hands over to the first bit of the next without shifting that register.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        parity_d      = parity_q;
        dout_d        = 1'b0;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        pre_shift     = 1'b0;
        data_shift    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = PRE;
                    cnt_d         = '0;
                    parity_d      = ^bus.in_data;
                    dout_d        = pre_bit;
                    dout_valid_d  = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            PRE: begin
                dout_valid_d = 1'b1;
                if (cnt_q == CNT_W'(PRE_W - 1)) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    dout_d  = data_bit;
                end else begin
                    pre_shift = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    dout_d    = pre_bit;
                end
            end
            DATA: begin
                dout_valid_d = 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = PAR;
                    cnt_d   = '0;
                    dout_d  = parity_q;
                end else begin
                    data_shift = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    dout_d     = data_bit;
                end
            end
            PAR: begin
                cnt_d   = '0;
                state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            parity_q      <= 1'b0;
            dout_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            parity_q      <= parity_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = (state_q != IDLE);

endmodule
